axi_lite_sram: RTL and testbench
================================

# axi_lite_sram

AXI4-Lite slave memory that sits directly downstream of the NPC AXI arbiter and consumes its single AR/R/AW/W/B master port. It holds a word-addressed register-array memory. Every request is answered after a configurable or pseudo-random latency so the arbiter, IFU and LSU handshakes are exercised under realistic stalls. Out-of-range accesses return SLVERR.

## Interface
Parameters:
- DEPTH_LOG2, 10: memory depth is 2**DEPTH_LOG2 32-bit words.
- BASE_ADDR, 32'h8000_0000: byte address of word 0.
- FIX_LATENCY, 2: wait cycles inserted per transaction when ARG is not defined (range 0..15).

Ports:
- clock  in  1  clock, all logic on posedge.
- reset  in  1  synchronous, active-high.
- araddr  in  32  read byte address.
- arvalid  in  1  read address valid.
- arready  out  1  read address ready.
- rdata  out  32  read data.
- rresp  out  2  read response (00 OKAY, 10 SLVERR).
- rvalid  out  1  read data valid.
- rready  in  1  read data ready.
- awaddr  in  32  write byte address.
- awvalid  in  1  write address valid.
- awready  out  1  write address ready.
- wdata  in  32  write data.
- wstrb  in  4  byte strobes; bit i enables byte i.
- wvalid  in  1  write data valid.
- wready  out  1  write data ready.
- bresp  out  2  write response.
- bvalid  out  1  write response valid.
- bready  in  1  write response ready.

## Operation
- In-range test: off = addr − BASE_ADDR (32-bit wrap). The address is in range iff off < 4·2**DEPTH_LOG2. The index is off[DEPTH_LOG2+1:2]. addr[1:0] is ignored.
- The read FSM and the write FSM are independent; both run concurrently.
- Read FSM:
  - R_IDLE: arready=1. On arvalid, register the address and the in-range flag, load the wait counter with LAT, and go to R_WAIT. If LAT=0, go directly to R_RESP.
  - R_WAIT: the counter decrements each cycle. When it reaches 1, go to R_RESP.
  - R_RESP: rvalid=1. rdata/rresp are held stable until rready, then return to R_IDLE.
  - rdata is registered from memory on the edge entering R_RESP. Out of range gives rdata=0, rresp=2'b10.
- Write FSM:
  - W_IDLE: awready=1. On awvalid, register the address and go to W_DATA.
  - W_DATA: wready=1. On wvalid, register wdata/wstrb, load the counter, and go to W_WAIT. If LAT=0, go to W_RESP.
  - W_WAIT: counts down exactly as R_WAIT does.
  - W_RESP: bvalid=1. Memory is written with the strobes on the edge entering W_RESP, only when the address is in range. bresp is 00 in range, 10 out of range. On bready, return to W_IDLE.
- Read/write collision on the same word: a read sampling on the same edge as a write commit returns the old data.
- Any undefined state encoding recovers to IDLE.

## Timing
- Reset values: arready=1, awready=1, wready=0, rvalid=0, bvalid=0, rdata=0, rresp=00, bresp=00. Memory contents are not reset.
- Reset asserted mid-transaction aborts it: no memory write and no response afterwards.
- AR handshake at edge t: rvalid rises at t+LAT+1.
- W handshake at edge t: bvalid rises at t+LAT+1.
- AW→W: wready is asserted in the cycle after the AW handshake.
- Readies are state-decoded (registered state), not combinational on valids.
- No outstanding-transaction pipelining: one read and one write in flight maximum.
- Back-to-back: after an R handshake at edge t, arready is high in cycle t+1.

## Configuration
- RANDOM_DELAY_EN undefined: LAT = FIX_LATENCY for both channels.
- RANDOM_DELAY_EN defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4) is seeded 8'hA5 on reset and advances every cycle.
  - A read latches LAT = lfsr[2:0] at AR handshake.
  - A write latches LAT = lfsr[6:4] at W handshake.
  - Range is 0..7 cycles. FIX_LATENCY is ignored.

## Test plan
- Write 0x8000_0010 data 0xDEADBEEF wstrb 1111, then read the same address (FIX_LATENCY=2) -> bresp=00; rvalid 3 cycles after AR handshake; rdata=0xDEADBEEF, rresp=00.
- Partial write wstrb=0010 data 0x0000_AB00 onto 0x1122_3344 -> read returns 0x1122_AB44.
- Read 0x7FFF_FFFC and write 0x8000_1000 (DEPTH_LOG2=10) -> rresp=10, rdata=0; bresp=10; the memory word at index 0 is unchanged.
- rready held low 5 cycles in R_RESP -> rvalid and rdata stable for all 5 cycles; arready=0 until the handshake completes.
- Concurrent read 0x8000_0020 and write 0x8000_0020 data 0x5 committing on the same edge as the read samples (old value 0x3) -> rdata=0x3; a later read returns 0x5.
- RANDOM_DELAY_EN defined, 100 random reads/writes -> every response latency lies in 1..8 cycles after its handshake; data matches a scoreboard; reset asserted mid-W_WAIT produces no bvalid and no memory update.

Source files
------------

// File: rtl/axi_lite_sram_if.sv
// AXI4-Lite AR/R/AW/W/B bundle between the NPC arbiter (master) and the SRAM model (slave).
interface axi_lite_sram_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axi_lite_sram.sv
// AXI4-Lite word memory answering every request after a wait-state delay.
// Define RANDOM_DELAY_EN to draw per-transaction latency (0..7) from an LFSR instead of FIX_LATENCY.
module axi_lite_sram #(
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned FIX_LATENCY = 2
) (
    input logic            clock,
    input logic            reset,
    axi_lite_sram_if.slave bus
);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} w_state_t;

    logic [31:0] mem [0:(1 << DEPTH_LOG2)-1];

    logic [31:0]           ar_off, aw_off;
    logic                  ar_ok, aw_ok;
    logic [DEPTH_LOG2-1:0] ar_idx, aw_idx;
    logic [3:0]            rd_lat, wr_lat;

    // 32-bit wrap on the subtraction makes addresses below BASE_ADDR fall out of range.
    assign ar_off = bus.araddr - BASE_ADDR;
    assign aw_off = bus.awaddr - BASE_ADDR;
    assign ar_ok  = (ar_off >> (DEPTH_LOG2 + 2)) == 32'd0;
    assign aw_ok  = (aw_off >> (DEPTH_LOG2 + 2)) == 32'd0;
    assign ar_idx = ar_off[DEPTH_LOG2+1:2];
    assign aw_idx = aw_off[DEPTH_LOG2+1:2];

`ifdef RANDOM_DELAY_EN
    logic [7:0] lfsr_q, lfsr_d;
    always_comb lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    always_ff @(posedge clock) begin
        if (reset) lfsr_q <= 8'hA5;
        else       lfsr_q <= lfsr_d;
    end
    assign rd_lat = {1'b0, lfsr_q[2:0]};
    assign wr_lat = {1'b0, lfsr_q[6:4]};
`else
    assign rd_lat = 4'(FIX_LATENCY);
    assign wr_lat = 4'(FIX_LATENCY);
`endif

    r_state_t              r_state_q, r_state_d;
    logic [3:0]            r_cnt_q, r_cnt_d;
    logic [DEPTH_LOG2-1:0] r_idx_q, r_idx_d;
    logic                  r_ok_q, r_ok_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;

    w_state_t              w_state_q, w_state_d;
    logic [3:0]            w_cnt_q, w_cnt_d;
    logic [DEPTH_LOG2-1:0] w_idx_q, w_idx_d;
    logic                  w_ok_q, w_ok_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  mem_we;
    logic [31:0]           mem_wdata;
    logic [3:0]            mem_wstrb;

    // Read channel: rdata is captured from memory on the edge that enters R_RESP.
    always_comb begin
        r_state_d = r_state_q;
        r_cnt_d   = r_cnt_q;
        r_idx_d   = r_idx_q;
        r_ok_d    = r_ok_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: if (bus.arvalid) begin
                r_idx_d = ar_idx;
                r_ok_d  = ar_ok;
                r_cnt_d = rd_lat;
                if (rd_lat == 4'd0) begin
                    r_state_d = R_RESP;
                    rdata_d   = ar_ok ? mem[ar_idx] : 32'd0;
                    rresp_d   = ar_ok ? RESP_OKAY : RESP_SLVERR;
                end else begin
                    r_state_d = R_WAIT;
                end
            end
            R_WAIT: begin
                r_cnt_d = r_cnt_q - 4'd1;
                if (r_cnt_q == 4'd1) begin
                    r_state_d = R_RESP;
                    rdata_d   = r_ok_q ? mem[r_idx_q] : 32'd0;
                    rresp_d   = r_ok_q ? RESP_OKAY : RESP_SLVERR;
                end
            end
            R_RESP: if (bus.rready) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    // Write channel: the memory commit happens on the edge that enters W_RESP.
    always_comb begin
        w_state_d = w_state_q;
        w_cnt_d   = w_cnt_q;
        w_idx_d   = w_idx_q;
        w_ok_d    = w_ok_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bresp_d   = bresp_q;
        mem_we    = 1'b0;
        mem_wdata = wdata_q;
        mem_wstrb = wstrb_q;
        case (w_state_q)
            W_IDLE: if (bus.awvalid) begin
                w_idx_d   = aw_idx;
                w_ok_d    = aw_ok;
                w_state_d = W_DATA;
            end
            W_DATA: if (bus.wvalid) begin
                wdata_d = bus.wdata;
                wstrb_d = bus.wstrb;
                w_cnt_d = wr_lat;
                if (wr_lat == 4'd0) begin
                    w_state_d = W_RESP;
                    mem_we    = w_ok_q;
                    mem_wdata = bus.wdata;
                    mem_wstrb = bus.wstrb;
                    bresp_d   = w_ok_q ? RESP_OKAY : RESP_SLVERR;
                end else begin
                    w_state_d = W_WAIT;
                end
            end
            W_WAIT: begin
                w_cnt_d = w_cnt_q - 4'd1;
                if (w_cnt_q == 4'd1) begin
                    w_state_d = W_RESP;
                    mem_we    = w_ok_q;
                    bresp_d   = w_ok_q ? RESP_OKAY : RESP_SLVERR;
                end
            end
            W_RESP: if (bus.bready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state_q <= R_IDLE;
            r_cnt_q   <= '0;
            r_idx_q   <= '0;
            r_ok_q    <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            w_state_q <= W_IDLE;
            w_cnt_q   <= '0;
            w_idx_q   <= '0;
            w_ok_q    <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= RESP_OKAY;
        end else begin
            r_state_q <= r_state_d;
            r_cnt_q   <= r_cnt_d;
            r_idx_q   <= r_idx_d;
            r_ok_q    <= r_ok_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            w_state_q <= w_state_d;
            w_cnt_q   <= w_cnt_d;
            w_idx_q   <= w_idx_d;
            w_ok_q    <= w_ok_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bresp_q   <= bresp_d;
        end
    end

    // Reset on the commit edge aborts the write; the array itself is never cleared.
    always_ff @(posedge clock) begin
        if (mem_we && !reset) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wstrb[b]) mem[w_idx_q][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    assign bus.arready = (r_state_q == R_IDLE);
    assign bus.rvalid  = (r_state_q == R_RESP);
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;
    assign bus.awready = (w_state_q == W_IDLE);
    assign bus.wready  = (w_state_q == W_DATA);
    assign bus.bvalid  = (w_state_q == W_RESP);
    assign bus.bresp   = bresp_q;
endmodule

// File: tb/tb_axi_lite_sram.sv
// Scoreboard bench for axi_lite_sram: directed cases then random traffic, latency and data checks.
module tb_axi_lite_sram;
    localparam int          DEPTH_LOG2 = 10;
    localparam logic [31:0] BASE       = 32'h8000_0000;
    localparam int          FIX_LAT    = 2;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    axi_lite_sram_if bus();

    axi_lite_sram #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .BASE_ADDR  (BASE),
        .FIX_LATENCY(FIX_LAT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    exp_t        rd_q[$];
    logic [1:0]  wr_q[$];
    logic [31:0] model [0:(1 << DEPTH_LOG2)-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic in_rng(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return off < 32'(4 << DEPTH_LOG2);
    endfunction

    function automatic logic [DEPTH_LOG2-1:0] widx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return off[DEPTH_LOG2+1:2];
    endfunction

    task automatic check_lat(input string tag, input int lat);
`ifdef RANDOM_DELAY_EN
        check(tag, 32'(lat >= 1 && lat <= 8), 32'd1);
`else
        check(tag, 32'(lat), 32'(FIX_LAT + 1));
`endif
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_arready"}, 32'(bus.arready), 32'd1);
        check({tag, "_awready"}, 32'(bus.awready), 32'd1);
        check({tag, "_wready"},  32'(bus.wready),  32'd0);
        check({tag, "_rvalid"},  32'(bus.rvalid),  32'd0);
        check({tag, "_bvalid"},  32'(bus.bvalid),  32'd0);
        check({tag, "_rdata"},   bus.rdata,        32'd0);
        check({tag, "_rresp"},   32'(bus.rresp),   32'd0);
        check({tag, "_bresp"},   32'(bus.bresp),   32'd0);
    endtask

    task automatic rd(input logic [31:0] addr, input int hold, output logic [31:0] data_obs);
        exp_t e;
        int   n;
        int   lat;
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        bus.rready  = 1'b0;
        n = 0;
        while (!bus.arready && n < 40) begin step(); n++; end
        check("arready_wait", 32'(bus.arready), 32'd1);
        e.resp = in_rng(addr) ? 2'b00 : 2'b10;
        e.data = in_rng(addr) ? model[widx(addr)] : 32'd0;
        rd_q.push_back(e);
        step();
        bus.arvalid = 1'b0;
        lat = 1;
        while (!bus.rvalid && lat < 40) begin step(); lat++; end
        check("rvalid_seen", 32'(bus.rvalid), 32'd1);
        check_lat("rd_lat", lat);
        e = rd_q.pop_front();
        data_obs = bus.rdata;
        check("rdata", bus.rdata, e.data);
        check("rresp", 32'(bus.rresp), 32'(e.resp));
        for (int i = 0; i < hold; i++) begin
            step();
            check("hold_rvalid",  32'(bus.rvalid),  32'd1);
            check("hold_rdata",   bus.rdata,        e.data);
            check("hold_arready", 32'(bus.arready), 32'd0);
        end
        bus.rready = 1'b1;
        step();
        bus.rready = 1'b0;
        check("rvalid_drop",  32'(bus.rvalid),  32'd0);
        check("arready_b2b",  32'(bus.arready), 32'd1);
        $display("rd addr=%h data=%h resp=%0d lat=%0d", addr, data_obs, e.resp, lat);
    endtask

    task automatic aw_phase(input logic [31:0] addr);
        int n;
        bus.awaddr  = addr;
        bus.awvalid = 1'b1;
        n = 0;
        while (!bus.awready && n < 40) begin step(); n++; end
        check("awready_wait", 32'(bus.awready), 32'd1);
        step();
        bus.awvalid = 1'b0;
        check("wready_after_aw", 32'(bus.wready), 32'd1);
    endtask

    task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        if (in_rng(addr)) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) model[widx(addr)][8*b +: 8] = data[8*b +: 8];
            end
        end
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        logic [1:0] eb;
        int         lat;
        aw_phase(addr);
        bus.wdata  = data;
        bus.wstrb  = strb;
        bus.wvalid = 1'b1;
        wr_q.push_back(in_rng(addr) ? 2'b00 : 2'b10);
        step();
        bus.wvalid = 1'b0;
        lat = 1;
        while (!bus.bvalid && lat < 40) begin step(); lat++; end
        check("bvalid_seen", 32'(bus.bvalid), 32'd1);
        check_lat("wr_lat", lat);
        eb = wr_q.pop_front();
        check("bresp", 32'(bus.bresp), 32'(eb));
        model_write(addr, data, strb);
        bus.bready = 1'b1;
        step();
        bus.bready = 1'b0;
        check("bvalid_drop", 32'(bus.bvalid),  32'd0);
        check("awready_b2b", 32'(bus.awready), 32'd1);
        $display("wr addr=%h data=%h strb=%h resp=%0d lat=%0d", addr, data, strb, eb, lat);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired got=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [31:0] a;
        logic [31:0] old5;
        logic        done;
        logic        seen_b;
        bus.araddr = '0; bus.arvalid = 0; bus.rready = 0;
        bus.awaddr = '0; bus.awvalid = 0; bus.wdata = '0; bus.wstrb = '0;
        bus.wvalid = 0;  bus.bready  = 0;

        repeat (3) step();
        check_idle("reset");
        reset = 1'b0;
        step();

        for (int i = 0; i < 16; i++) wr(BASE + 32'(4 * i), $urandom, 4'hF);

        wr(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF);
        rd(BASE + 32'h10, 0, d);
        check("full_word", d, 32'hDEAD_BEEF);

        wr(BASE + 32'h18, 32'h1122_3344, 4'hF);
        wr(BASE + 32'h18, 32'h0000_AB00, 4'b0010);
        rd(BASE + 32'h18, 0, d);
        check("partial_word", d, 32'h1122_AB44);

        rd(32'h7FFF_FFFC, 0, d);
        wr(BASE + 32'h1000, 32'hCAFE_F00D, 4'hF);
        rd(BASE, 0, d);

        rd(BASE + 32'h10, 5, d);

`ifndef RANDOM_DELAY_EN
        // Read sample and write commit land on the same edge.
        begin
            exp_t       e;
            logic [1:0] eb;
            logic       got_r;
            logic       got_b;
            wr(BASE + 32'h20, 32'h3, 4'hF);
            aw_phase(BASE + 32'h20);
            e.data = model[8];
            e.resp = 2'b00;
            rd_q.push_back(e);
            wr_q.push_back(2'b00);
            bus.araddr  = BASE + 32'h20; bus.arvalid = 1'b1;
            bus.wdata   = 32'h5; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
            bus.rready  = 1'b1; bus.bready = 1'b1;
            step();
            bus.arvalid = 1'b0;
            bus.wvalid  = 1'b0;
            model[8] = 32'h5;
            got_r = 1'b0;
            got_b = 1'b0;
            for (int c = 1; c <= 10 && !(got_r && got_b); c++) begin
                if (bus.rvalid && !got_r) begin
                    got_r = 1'b1;
                    e = rd_q.pop_front();
                    check("coll_rdata", bus.rdata, e.data);
                    check("coll_rlat", 32'(c), 32'(FIX_LAT + 1));
                end
                if (bus.bvalid && !got_b) begin
                    got_b = 1'b1;
                    eb = wr_q.pop_front();
                    check("coll_bresp", 32'(bus.bresp), 32'(eb));
                    check("coll_blat", 32'(c), 32'(FIX_LAT + 1));
                end
                step();
            end
            check("coll_r_seen", 32'(got_r), 32'd1);
            check("coll_b_seen", 32'(got_b), 32'd1);
            bus.rready = 1'b0;
            bus.bready = 1'b0;
            $display("collision rd/wr addr=%h", BASE + 32'h20);
            rd(BASE + 32'h20, 0, d);
            check("coll_after", d, 32'h5);
        end
`endif

        for (int i = 0; i < 100; i++) begin
            if ($urandom_range(0, 7) == 0)
                a = ($urandom_range(0, 1) == 0) ? BASE - 32'd4 : BASE + 32'h1000 + 32'(4 * $urandom_range(0, 15));
            else
                a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) wr(a, $urandom, 4'($urandom_range(1, 15)));
            else                           rd(a, $urandom_range(0, 2), d);
        end

        // Reset while the write waits out its latency must drop it entirely.
        done = 1'b0;
        for (int t = 0; t < 20 && !done; t++) begin
            old5 = model[5];
            aw_phase(BASE + 32'h14);
            bus.wdata  = ~old5;
            bus.wstrb  = 4'hF;
            bus.wvalid = 1'b1;
            step();
            bus.wvalid = 1'b0;
            if (!bus.bvalid) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
                done = 1'b1;
            end else begin
                model_write(BASE + 32'h14, ~old5, 4'hF);
                bus.bready = 1'b1;
                step();
                bus.bready = 1'b0;
                step();
            end
        end
        check("rst_attempt", 32'(done), 32'd1);
        check_idle("midrst");
        seen_b = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (bus.bvalid) seen_b = 1'b1;
            step();
        end
        check("midrst_no_bvalid", 32'(seen_b), 32'd0);
        $display("reset abort of write addr=%h", BASE + 32'h14);
        rd(BASE + 32'h14, 0, d);
        check("midrst_mem", d, old5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
